switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 2, meaning the number of independent switch channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive synchronized samples required before an output changes; the board build uses 1_000_000 at 50 MHz.
REQ-003 SHALL have port clock  input  1  system clock; all state is updated on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sw_in  input  WIDTH  raw, asynchronous, bouncing switch levels.
REQ-006 SHALL have port sw_out  output  WIDTH  debounced level per channel, registered; feeds the downstream latch/flip-flop stage as its D or clock input.
REQ-007 SHALL have port rise  output  WIDTH  one-cycle pulse per channel on a debounced 0->1 change.
REQ-008 SHALL have port fall  output  WIDTH  one-cycle pulse per channel on a debounced 1->0 change.

Function
REQ-009 SHALL pass each sw_in bit through a two-flop synchronizer; the second flop output is "sync".
REQ-010 SHALL run one two-state FSM per channel, STABLE and COUNTING, with a counter of width $clog2(STABLE_CYCLES+1).
REQ-011 STABLE: if sync != sw_out, the FSM SHALL go to COUNTING with count=1; otherwise it holds with count=0.
REQ-012 COUNTING: if sync == sw_out (bounce back), the FSM SHALL return to STABLE with count=0 and sw_out unchanged.
REQ-013 COUNTING: if sync != sw_out and count == STABLE_CYCLES-1, the FSM SHALL set sw_out <= sync, go to STABLE and clear count; otherwise it increments count.
REQ-014 For STABLE_CYCLES == 1, the update SHALL occur on the first edge that samples sync != sw_out.
REQ-015 Latency: a clean sw_in change set up before edge N SHALL appear on sw_out after edge N+1+STABLE_CYCLES, i.e. 6 edges at default.
REQ-016 rise/fall SHALL be registered, assert on the same edge sw_out changes, and deassert on the next edge; rise and fall of one channel SHALL never be high together.
REQ-017 Channels SHALL be fully independent, including simultaneous changes on several channels.
REQ-018 A bounce shorter than STABLE_CYCLES samples SHALL produce no sw_out change and no pulse.
REQ-019 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While resetn=0, the synchronizer flops, sw_out, rise, fall and count SHALL be 0, and every FSM SHALL be in STABLE, taking effect immediately without a clock.
REQ-021 Reset asserted mid-count SHALL abort the count; after release, a switch held high SHALL yield sw_out=1 and one rise pulse after STABLE_CYCLES+2 edges.

Configuration
REQ-022 Macro SWITCH_DEBOUNCER_EDGE_EN SHALL, when defined, generate the rise/fall registers as in REQ-016.
REQ-023 When SWITCH_DEBOUNCER_EDGE_EN is undefined, rise and fall SHALL be tied to 0 with no edge registers, and sw_out behaviour SHALL be identical.

Structure
REQ-024 Package debounce_pkg SHALL hold the FSM state typedef (STABLE, COUNTING) and the default STABLE_CYCLES constants for simulation (4) and board (1_000_000).
REQ-025 Sub-module debounce_channel SHALL implement the synchronizer, FSM, counter and edge logic for one bit; the top SHALL instantiate it WIDTH times.
REQ-026 STABLE_CYCLES < 1 SHALL be rejected at elaboration.

Verification
REQ-027 Reset, then sw_in=2'b01 held -> sw_out=2'b01 after 6 edges, rise=2'b01 for exactly 1 cycle, fall=0.
REQ-028 sw_in[0] toggles 0->1->0->1 with 2 cycles per level, then holds 1 -> no change until 6 edges after the last toggle, then a single rise pulse.
REQ-029 sw_in 2'b11 -> 2'b00 simultaneously -> both sw_out bits fall on the same edge, fall=2'b11 for 1 cycle.
REQ-030 resetn pulsed low at count=2 with sw_in=1 -> outputs 0 immediately; after release, sw_out=1 on edge 6.
REQ-031 Build without SWITCH_DEBOUNCER_EDGE_EN and rerun REQ-027 -> identical sw_out, with rise=fall=0 throughout.
REQ-032 STABLE_CYCLES=1 -> sw_out follows a clean sw_in change after 3 edges.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constants for the switch debouncer
//
// Holds the per-channel FSM state encoding and the default stability
// windows: a short one for simulation and the real one for the 50 MHz board.
// No ports.

package debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  localparam int SIM_STABLE_CYCLES   = 4;
  localparam int BOARD_STABLE_CYCLES = 1_000_000;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-bit synchronizer, debounce FSM and edge pulses
//
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (rise/fall registers).
//
// Ports:
//   clock   in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   sw_in   in   raw bouncing switch level
//   sw_out  out  debounced level, registered
//   rise    out  one-cycle pulse on debounced 0->1 (0 when edge feature off)
//   fall    out  one-cycle pulse on debounced 1->0 (0 when edge feature off)

module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SIM_STABLE_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic sw_in,
  output logic sw_out,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_bad_param
    $error("debounce_channel: STABLE_CYCLES must be at least 1");
  end

  logic          meta_q;
  logic          sync_q;
  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          sw_out_q, sw_out_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sw_out_d = sw_out_q;
    unique case (state_q)
      STABLE: begin
        count_d = '0;
        if (sync_q != sw_out_q) begin
          // A one-sample window means the first differing sample is enough.
          if (STABLE_CYCLES == 1) begin
            sw_out_d = sync_q;
          end else begin
            state_d = COUNTING;
            count_d = CW'(1);
          end
        end
      end
      COUNTING: begin
        if (sync_q == sw_out_q) begin
          // Bounced back before the window filled: forget the attempt.
          state_d = STABLE;
          count_d = '0;
        end else if (count_q == LAST) begin
          sw_out_d = sync_q;
          state_d  = STABLE;
          count_d  = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      state_q  <= STABLE;
      count_q  <= '0;
      sw_out_q <= 1'b0;
    end else begin
      meta_q   <= sw_in;
      sync_q   <= meta_q;
      state_q  <= state_d;
      count_q  <= count_d;
      sw_out_q <= sw_out_d;
    end
  end

  assign sw_out = sw_out_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Derived from the next output value so the pulse lands on the same edge
  // as the sw_out change; rise and fall are mutually exclusive by construction.
  always_comb begin
    rise_d = sw_out_d & ~sw_out_q;
    fall_d = ~sw_out_d & sw_out_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - multi-channel switch debouncer top
//
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN (rise/fall registers).
//
// Ports:
//   clock   in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   sw_in   in   [WIDTH] raw bouncing switch levels
//   sw_out  out  [WIDTH] debounced levels, registered
//   rise    out  [WIDTH] one-cycle pulse per channel on debounced 0->1
//   fall    out  [WIDTH] one-cycle pulse per channel on debounced 1->0

module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = SIM_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clock (clock),
      .resetn(resetn),
      .sw_in (sw_in[i]),
      .sw_out(sw_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer

module tb_switch_debouncer;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic [1:0] sw_in;
  logic [1:0] sw_out, rise, fall;
  logic [0:0] sw_in1;
  logic [0:0] sw_out1, rise1, fall1;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt;

  switch_debouncer #(.WIDTH(2), .STABLE_CYCLES(4)) u_dut (
    .clock (clock),
    .resetn(resetn),
    .sw_in (sw_in),
    .sw_out(sw_out),
    .rise  (rise),
    .fall  (fall)
  );

  switch_debouncer #(.WIDTH(1), .STABLE_CYCLES(1)) u_dut1 (
    .clock (clock),
    .resetn(resetn),
    .sw_in (sw_in1),
    .sw_out(sw_out1),
    .rise  (rise1),
    .fall  (fall1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] sw;
    int         edges;
    logic [1:0] exp_out;
    logic [1:0] exp_rise;
    logic [1:0] exp_fall;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges, then stop at the following falling edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // sw_in, edges to wait, expected sw_out/rise/fall (rise/fall before masking)
    vecs[0]  = '{2'b01, 5, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 1, 2'b01, 2'b01, 2'b00};
    vecs[2]  = '{2'b01, 1, 2'b01, 2'b00, 2'b00};
    vecs[3]  = '{2'b11, 5, 2'b01, 2'b00, 2'b00};
    vecs[4]  = '{2'b11, 1, 2'b11, 2'b10, 2'b00};
    vecs[5]  = '{2'b11, 1, 2'b11, 2'b00, 2'b00};
    vecs[6]  = '{2'b00, 5, 2'b11, 2'b00, 2'b00};
    vecs[7]  = '{2'b00, 1, 2'b00, 2'b00, 2'b11};
    vecs[8]  = '{2'b00, 1, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{2'b10, 6, 2'b10, 2'b10, 2'b00};
    vecs[10] = '{2'b01, 5, 2'b10, 2'b00, 2'b00};
    vecs[11] = '{2'b01, 1, 2'b01, 2'b01, 2'b10};
    vecs[12] = '{2'b01, 1, 2'b01, 2'b00, 2'b00};

    resetn = 1'b0;
    sw_in  = 2'b00;
    sw_in1 = 1'b0;
    wait_edges(3);
    chk("reset_sw_out", 32'(sw_out), 32'd0);
    chk("reset_rise",   32'(rise),   32'd0);
    chk("reset_fall",   32'(fall),   32'd0);
    chk("reset_sw_out1", 32'(sw_out1), 32'd0);
    resetn = 1'b1;
    wait_edges(2);
    chk("idle_sw_out", 32'(sw_out), 32'd0);

    // Table: single-channel rise, both rise, simultaneous fall, opposite moves.
    for (int i = 0; i < 13; i++) begin
      sw_in = vecs[i].sw;
      wait_edges(vecs[i].edges);
      chk($sformatf("vec%0d_sw_out", i), 32'(sw_out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_rise", i),   32'(rise),   32'(vecs[i].exp_rise & {2{EDGE_EN}}));
      chk($sformatf("vec%0d_fall", i),   32'(fall),   32'(vecs[i].exp_fall & {2{EDGE_EN}}));
    end

    // Bounce on channel 0: 1,0,1 with two cycles per level, then held high.
    sw_in = 2'b00;
    wait_edges(8);
    chk("bounce_pre_sw_out", 32'(sw_out), 32'd0);
    rise_cnt = 0;
    for (int e = 1; e <= 11; e++) begin
      if (e == 1) sw_in[0] = 1'b1;
      if (e == 3) sw_in[0] = 1'b0;
      if (e == 5) sw_in[0] = 1'b1;
      wait_edges(1);
      if (rise[0]) rise_cnt++;
      chk($sformatf("bounce_e%0d_sw_out", e), 32'(sw_out), (e >= 10) ? 32'd1 : 32'd0);
      chk($sformatf("bounce_e%0d_rise", e), 32'(rise), (EDGE_EN && e == 10) ? 32'd1 : 32'd0);
      chk($sformatf("bounce_e%0d_fall", e), 32'(fall), 32'd0);
    end
    chk("bounce_rise_count", 32'(rise_cnt), EDGE_EN ? 32'd1 : 32'd0);

    // Reset mid-count: channel 1 at count 2, channel 0 already high.
    sw_in = 2'b11;
    wait_edges(4);
    chk("midcount_sw_out", 32'(sw_out), 32'b01);
    resetn = 1'b0;
    #1;
    chk("async_reset_sw_out", 32'(sw_out), 32'd0);
    chk("async_reset_rise",   32'(rise),   32'd0);
    chk("async_reset_fall",   32'(fall),   32'd0);
    wait_edges(2);
    chk("held_reset_sw_out", 32'(sw_out), 32'd0);
    resetn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      wait_edges(1);
      chk($sformatf("post_reset_e%0d_sw_out", e), 32'(sw_out), (e >= 6) ? 32'b11 : 32'b00);
      chk($sformatf("post_reset_e%0d_rise", e), 32'(rise), (EDGE_EN && e == 6) ? 32'b11 : 32'b00);
      chk($sformatf("post_reset_e%0d_fall", e), 32'(fall), 32'd0);
    end

    // One-sample window: output follows a clean change after three edges.
    sw_in1 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      wait_edges(1);
      chk($sformatf("sc1_up_e%0d_sw_out", e), 32'(sw_out1), (e >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("sc1_up_e%0d_rise", e), 32'(rise1), (EDGE_EN && e == 3) ? 32'd1 : 32'd0);
    end
    sw_in1 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      wait_edges(1);
      chk($sformatf("sc1_dn_e%0d_sw_out", e), 32'(sw_out1), (e >= 3) ? 32'd0 : 32'd1);
      chk($sformatf("sc1_dn_e%0d_fall", e), 32'(fall1), (EDGE_EN && e == 3) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_switch_debouncer
